debug_dump_control: RTL and testbench

DEBUG_DUMP_CONTROL -- requirements
Module: debug_dump_control

---
 rtl/debug_dump_control.sv | 220 ++++++++++++++++++++++
 tb/tb_debug_dump_control.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_dump_control.sv
// rtl/debug_dump_control.sv - byte-serial dump of PC, register bank, data memory and cycle count
// Define DUMP_CHECKSUM_EN to append one XOR checksum byte after the cycle count.
module debug_dump_control #(
   parameter int WORD_WIDTH     = 32,
   parameter int DM_ADDR_LENGTH = 32,
   parameter int DM_DEPTH       = 1024,
   parameter int RBITS          = 5,
   parameter int RB_DEPTH       = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      send_flag,
   input  logic                      tx_done,
   input  logic [WORD_WIDTH-1:0]     current_pc,
   input  logic [WORD_WIDTH-1:0]     clock_count,
   input  logic [WORD_WIDTH-1:0]     DM_Data,
   input  logic [WORD_WIDTH-1:0]     RB_Data,
   output logic [DM_ADDR_LENGTH-1:0] DM_Addr,
   output logic [RBITS-1:0]          RB_Addr,
   output logic [7:0]                tx_Data,
   output logic                      tx_start,
   output logic                      busy,
   output logic                      send_done
);

   localparam int NBYTES = WORD_WIDTH / 8;
   localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [BW-1:0]             LAST_BYTE = BW'(NBYTES - 1);
   localparam logic [RBITS-1:0]          LAST_RB   = RBITS'(RB_DEPTH - 1);
   localparam logic [DM_ADDR_LENGTH-1:0] LAST_DM   = DM_ADDR_LENGTH'(DM_DEPTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      FETCH,
      LOAD,
      SEND,
      WAIT_TX,
      NEXT
`ifdef DUMP_CHECKSUM_EN
      , CSUM
`endif
   } state_t;

   typedef enum logic [2:0] {
      SEC_PC,
      SEC_RB,
      SEC_DM,
      SEC_CC
`ifdef DUMP_CHECKSUM_EN
      , SEC_CS
`endif
   } sec_t;

   state_t                state_q, state_d;
   sec_t                  sec_q;
   logic [BW-1:0]         byte_idx;
   logic [WORD_WIDTH-1:0] word_q;
   logic [WORD_WIDTH-1:0] sel_word;
   logic [WORD_WIDTH-1:0] pc_snap;
   logic [WORD_WIDTH-1:0] cc_snap;
   logic                  last_byte;
`ifdef DUMP_CHECKSUM_EN
   logic [7:0]            csum_q;
`endif

   assign last_byte = (byte_idx == LAST_BYTE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (send_flag) state_d = ADDR;
         ADDR:    state_d = FETCH;
         FETCH:   state_d = LOAD;
         LOAD:    state_d = SEND;
         SEND:    state_d = WAIT_TX;
         WAIT_TX: if (tx_done) state_d = NEXT;
         NEXT: begin
`ifdef DUMP_CHECKSUM_EN
            if (sec_q == SEC_CS) begin
               state_d = IDLE;
            end else
`endif
            if (!last_byte) begin
               state_d = SEND;
            end else if (sec_q == SEC_CC) begin
`ifdef DUMP_CHECKSUM_EN
               state_d = CSUM;
`else
               state_d = IDLE;
`endif
            end else begin
               state_d = ADDR;
            end
         end
`ifdef DUMP_CHECKSUM_EN
         CSUM:    state_d = WAIT_TX;
`endif
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      sel_word = '0;
      case (sec_q)
         SEC_PC:  sel_word = pc_snap;
         SEC_RB:  sel_word = RB_Data;
         SEC_DM:  sel_word = DM_Data;
         SEC_CC:  sel_word = cc_snap;
         default: sel_word = '0;
      endcase
   end

   // Word bytes leave LSB first: word_q shifts right by one byte per NEXT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sec_q     <= SEC_PC;
         byte_idx  <= '0;
         word_q    <= '0;
         pc_snap   <= '0;
         cc_snap   <= '0;
         DM_Addr   <= '0;
         RB_Addr   <= '0;
         tx_Data   <= '0;
         tx_start  <= 1'b0;
         busy      <= 1'b0;
         send_done <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         tx_start  <= 1'b0;
         send_done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (send_flag) begin
                  pc_snap  <= current_pc;
                  cc_snap  <= clock_count;
                  busy     <= 1'b1;
                  sec_q    <= SEC_PC;
                  byte_idx <= '0;
                  DM_Addr  <= '0;
                  RB_Addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
                  csum_q   <= '0;
`endif
               end
            end
            LOAD: word_q <= sel_word;
            SEND: begin
               tx_Data  <= word_q[7:0];
               tx_start <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
               csum_q   <= csum_q ^ word_q[7:0];
`endif
            end
`ifdef DUMP_CHECKSUM_EN
            CSUM: begin
               tx_Data  <= csum_q;
               tx_start <= 1'b1;
            end
`endif
            NEXT: begin
`ifdef DUMP_CHECKSUM_EN
               if (sec_q == SEC_CS) begin
                  busy      <= 1'b0;
                  send_done <= 1'b1;
                  sec_q     <= SEC_PC;
               end else
`endif
               if (!last_byte) begin
                  byte_idx <= byte_idx + 1'b1;
                  word_q   <= word_q >> 8;
               end else begin
                  byte_idx <= '0;
                  case (sec_q)
                     SEC_PC: sec_q <= SEC_RB;
                     SEC_RB: begin
                        if (RB_Addr == LAST_RB) begin
                           RB_Addr <= '0;
                           sec_q   <= SEC_DM;
                        end else begin
                           RB_Addr <= RB_Addr + 1'b1;
                        end
                     end
                     SEC_DM: begin
                        if (DM_Addr == LAST_DM) begin
                           DM_Addr <= '0;
                           sec_q   <= SEC_CC;
                        end else begin
                           DM_Addr <= DM_Addr + 1'b1;
                        end
                     end
                     SEC_CC: begin
`ifdef DUMP_CHECKSUM_EN
                        sec_q     <= SEC_CS;
`else
                        busy      <= 1'b0;
                        send_done <= 1'b1;
                        sec_q     <= SEC_PC;
`endif
                     end
                     default: sec_q <= SEC_PC;
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump_control.sv
// tb/tb_debug_dump_control.sv - randomized scoreboard bench for debug_dump_control
module tb_debug_dump_control;

   localparam int RBD = 4;
   localparam int DMD = 4;
`ifdef DUMP_CHECKSUM_EN
   localparam int DUMP_BYTES = (RBD + DMD + 2) * 4 + 1;
`else
   localparam int DUMP_BYTES = (RBD + DMD + 2) * 4;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        send_flag;
   logic        tx_done;
   logic [31:0] current_pc;
   logic [31:0] clock_count;
   logic [31:0] DM_Data;
   logic [31:0] RB_Data;
   logic [31:0] DM_Addr;
   logic [4:0]  RB_Addr;
   logic [7:0]  tx_Data;
   logic        tx_start;
   logic        busy;
   logic        send_done;

   logic [31:0] rb_mem [RBD];
   logic [31:0] dm_mem [DMD];
   logic [7:0]  exp_q [$];
   int          tests = 0;
   int          fails = 0;
   int          bytes_seen = 0;
   int          done_cnt = 0;
   int          ndone = 0;
   logic        withhold = 1'b0;

   debug_dump_control #(
      .WORD_WIDTH(32), .DM_ADDR_LENGTH(32), .DM_DEPTH(DMD), .RBITS(5), .RB_DEPTH(RBD)
   ) dut (
      .clk(clk), .reset(reset), .send_flag(send_flag), .tx_done(tx_done),
      .current_pc(current_pc), .clock_count(clock_count),
      .DM_Data(DM_Data), .RB_Data(RB_Data), .DM_Addr(DM_Addr), .RB_Addr(RB_Addr),
      .tx_Data(tx_Data), .tx_start(tx_start), .busy(busy), .send_done(send_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Memories with a one-cycle synchronous read.
   always @(posedge clk) begin
      RB_Data <= (RB_Addr < 5'(RBD)) ? rb_mem[RB_Addr[1:0]] : 32'hDEAD_0000;
      DM_Data <= (DM_Addr < 32'(DMD)) ? dm_mem[DM_Addr[1:0]] : 32'hDEAD_0001;
   end

   // UART model: tx_done three cycles after tx_start, or 100 cycles when withheld.
   always begin
      logic [7:0] held;
      int bad;
      @(posedge clk); #1;
      if (tx_start) begin
         if (withhold) begin
            held = tx_Data;
            bad = 0;
            for (int i = 0; i < 100; i++) begin
               @(posedge clk); #1;
               if (tx_start || tx_Data !== held) bad++;
            end
            check("withhold_stable", bad, 0);
            withhold = 1'b0;
            tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
         end else begin
            repeat (2) @(posedge clk);
            #1 tx_done = 1'b1;
            @(posedge clk); #1 tx_done = 1'b0;
         end
      end
   end

   // Monitor: byte order, address hold rules and per-dump byte count.
   always @(posedge clk) begin
      int k;
      int exp_rb;
      int exp_dm;
      logic [7:0] b;
      #1;
      if (tx_start) begin
         k = bytes_seen;
         exp_rb = (k >= 4 && k < 4 + 4 * RBD) ? (k - 4) / 4 : 0;
         exp_dm = (k >= 4 + 4 * RBD && k < 4 + 4 * (RBD + DMD)) ? (k - 4 - 4 * RBD) / 4 : 0;
         if (exp_q.size() == 0) begin
            check("unexpected_tx_start", 1, 0);
         end else begin
            b = exp_q.pop_front();
            check("tx_byte", tx_Data, b);
         end
         check("rb_addr", RB_Addr, exp_rb);
         check("dm_addr", DM_Addr, exp_dm);
         bytes_seen++;
      end
      if (send_done) begin
         check("byte_count", bytes_seen, DUMP_BYTES);
         check("busy_clear_at_done", busy, 0);
         bytes_seen = 0;
         done_cnt++;
      end
   end

   task automatic push_dump(input logic [31:0] pc, input logic [31:0] cc);
      logic [31:0] words [$];
      logic [7:0]  x;
      x = 8'h00;
      words.push_back(pc);
      for (int i = 0; i < RBD; i++) words.push_back(rb_mem[i]);
      for (int i = 0; i < DMD; i++) words.push_back(dm_mem[i]);
      words.push_back(cc);
      foreach (words[w]) begin
         for (int j = 0; j < 4; j++) begin
            exp_q.push_back(8'((words[w] >> (8 * j)) & 32'hFF));
            x = x ^ 8'((words[w] >> (8 * j)) & 32'hFF);
         end
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   task automatic start_dump(input logic [31:0] pc, input logic [31:0] cc);
      int n;
      current_pc = pc;
      clock_count = cc;
      push_dump(pc, cc);
      send_flag = 1'b1;
      @(posedge clk); #1 send_flag = 1'b0;
      check("busy_after_accept", busy, 1);
      n = 0;
      while (!tx_start && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("first_tx_latency", n, 4);
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      check("send_done_count", done_cnt, target);
   endtask

   task automatic randomize_mems();
      for (int i = 0; i < RBD; i++) rb_mem[i] = $urandom;
      for (int i = 0; i < DMD; i++) dm_mem[i] = $urandom;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b0;
      send_flag = 1'b0;
      tx_done = 1'b0;
      current_pc = '0;
      clock_count = '0;
      for (int i = 0; i < RBD; i++) rb_mem[i] = '0;
      for (int i = 0; i < DMD; i++) dm_mem[i] = '0;
      idle(3);
      check("rst_tx_start", tx_start, 0);
      check("rst_busy", busy, 0);
      check("rst_send_done", send_done, 0);
      check("rst_tx_data", tx_Data, 0);
      check("rst_dm_addr", DM_Addr, 0);
      check("rst_rb_addr", RB_Addr, 0);
      reset = 1'b1;
      idle(3);

      // Reference dump pattern
      for (int i = 0; i < RBD; i++) rb_mem[i] = i;
      for (int i = 0; i < DMD; i++) dm_mem[i] = 32'hA0 + i;
      start_dump(32'h1122_3344, 32'h0000_0010);
      wait_done(++ndone);
      idle(3);

      // Snapshot: inputs move after acceptance
      randomize_mems();
      start_dump($urandom, $urandom);
      current_pc = $urandom;
      clock_count = $urandom;
      idle(60);
      current_pc = $urandom;
      clock_count = $urandom;
      wait_done(++ndone);
      idle(3);

      // send_flag pulsed while busy
      randomize_mems();
      start_dump($urandom, $urandom);
      idle(40);
      current_pc = $urandom;
      send_flag = 1'b1;
      idle(1);
      send_flag = 1'b0;
      wait_done(++ndone);
      idle(20);
      check("no_extra_dump", done_cnt, ndone);
      check("idle_after_dump", busy, 0);

      // tx_done withheld on the first byte
      randomize_mems();
      withhold = 1'b1;
      start_dump($urandom, $urandom);
      wait_done(++ndone);
      idle(3);

      // send_flag held high across a finish: two back-to-back dumps
      randomize_mems();
      current_pc = $urandom;
      clock_count = $urandom;
      push_dump(current_pc, clock_count);
      push_dump(current_pc, clock_count);
      send_flag = 1'b1;
      wait_done(++ndone);
      wait_done(++ndone);
      send_flag = 1'b0;
      idle(20);
      check("held_flag_two_dumps", done_cnt, ndone);

      // Random dumps
      for (int r = 0; r < 3; r++) begin
         randomize_mems();
         start_dump($urandom, $urandom);
         wait_done(++ndone);
         idle($urandom_range(1, 5));
      end

      // Reset during DM[2] byte 1, then restart from PC
      for (int i = 0; i < RBD; i++) rb_mem[i] = i;
      for (int i = 0; i < DMD; i++) dm_mem[i] = 32'hA0 + i;
      start_dump(32'h1122_3344, 32'h0000_0010);
      n = 0;
      while (bytes_seen < 30 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("reach_dm2_byte1", bytes_seen, 30);
      check("dm_addr_before_abort", DM_Addr, 2);
      reset = 1'b0;
      #1;
      check("abort_tx_start", tx_start, 0);
      check("abort_busy", busy, 0);
      check("abort_send_done", send_done, 0);
      check("abort_tx_data", tx_Data, 0);
      check("abort_dm_addr", DM_Addr, 0);
      check("abort_rb_addr", RB_Addr, 0);
      exp_q.delete();
      bytes_seen = 0;
      idle(3);
      reset = 1'b1;
      idle(12);
      check("no_done_after_abort", done_cnt, ndone);
      start_dump(32'h1122_3344, 32'h0000_0010);
      wait_done(++ndone);
      idle(3);

      // Checksum pattern (checksum byte expected only when enabled)
      for (int i = 0; i < RBD; i++) rb_mem[i] = '0;
      for (int i = 0; i < DMD; i++) dm_mem[i] = '0;
      start_dump(32'h0000_0004, 32'h0000_0010);
      wait_done(++ndone);
      idle(5);
      check("queue_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
